// File: rtl/err_round_seq.sv
// Error-compensation sequencer: rounds each error product toward a 2^S step with a
// bit-serial restoring divider and accumulates the rounded values over a vector.
module err_round_seq #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned M_BITS = 14,
  parameter int unsigned ACC_W  = 24,
  parameter int unsigned LEN_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [LEN_W-1:0]  vec_len,
  input  logic              err_valid,
  output logic              err_ready,
  input  logic [DATA_W-1:0] error_product,
  output logic              comp_valid,
  input  logic              comp_ready,
  output logic [ACC_W-1:0]  comp_value,
  output logic              comp_ovf,
  output logic              busy
);

  localparam int unsigned S     = DATA_W - M_BITS;
  localparam int unsigned REM_W = S + 1;
  localparam int unsigned CNT_W = $clog2(DATA_W + 1);

  localparam logic [REM_W-1:0] DIVISOR  = REM_W'(1) << S;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] LOAD = 3'd1;
  localparam logic [2:0] DIV  = 3'd2;
  localparam logic [2:0] ACC  = 3'd3;
  localparam logic [2:0] OUT  = 3'd4;

  logic [2:0]        state_q, state_d;
  logic [LEN_W-1:0]  vec_len_q, vec_len_d;
  logic [LEN_W-1:0]  count_q, count_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic              ovf_q, ovf_d;
  logic              x_msb_q, x_msb_d;
  logic [DATA_W-1:0] sh_q, sh_d;
  logic [DATA_W-1:0] quo_q, quo_d;
  logic [REM_W-1:0]  rem_q, rem_d;
  logic [CNT_W-1:0]  bit_q, bit_d;
  logic              err_ready_q, err_ready_d;
  logic              comp_valid_q, comp_valid_d;
  logic              busy_q, busy_d;

  logic [REM_W-1:0]  rem_sh;
  logic [DATA_W-1:0] rounded;
  logic [ACC_W:0]    sum;

  // Next-state and datapath update
  always_comb begin
    state_d   = state_q;
    vec_len_d = vec_len_q;
    count_d   = count_q;
    acc_d     = acc_q;
    ovf_d     = ovf_q;
    x_msb_d   = x_msb_q;
    sh_d      = sh_q;
    quo_d     = quo_q;
    rem_d     = rem_q;
    bit_d     = bit_q;
    rem_sh    = '0;
    rounded   = '0;
    sum       = '0;

    case (state_q)
      IDLE: begin
        if (start) begin
          vec_len_d = vec_len;
          acc_d     = '0;
          count_d   = '0;
          ovf_d     = 1'b0;
          state_d   = (vec_len == '0) ? OUT : LOAD;
        end
      end
      LOAD: begin
        if (err_valid && err_ready_q) begin
          x_msb_d = error_product[DATA_W-1];
          sh_d    = error_product;
          quo_d   = '0;
          rem_d   = '0;
          bit_d   = '0;
          state_d = DIV;
        end
      end
      DIV: begin
        // Remainder stays below 2^S, so the dropped top bit of the shift is always zero
        rem_sh = REM_W'({rem_q, sh_q[DATA_W-1]});
        if (rem_sh >= DIVISOR) begin
          rem_d = rem_sh - DIVISOR;
          quo_d = DATA_W'({quo_q, 1'b1});
        end else begin
          rem_d = rem_sh;
          quo_d = DATA_W'({quo_q, 1'b0});
        end
        sh_d  = sh_q << 1;
        bit_d = bit_q + CNT_W'(1);
        if (bit_q == LAST_BIT) begin
          state_d = ACC;
        end
      end
      ACC: begin
        rounded = (quo_q + DATA_W'(x_msb_q)) << S;
        sum     = {1'b0, acc_q} + (ACC_W + 1)'(rounded);
        if (sum[ACC_W]) begin
          acc_d = '1;
          ovf_d = 1'b1;
        end else begin
          acc_d = sum[ACC_W-1:0];
        end
        count_d = count_q + LEN_W'(1);
        state_d = (count_d == vec_len_q) ? OUT : LOAD;
      end
      OUT: begin
        if (comp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    err_ready_d  = (state_d == LOAD);
    comp_valid_d = (state_d == OUT);
    busy_d       = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      vec_len_q    <= '0;
      count_q      <= '0;
      acc_q        <= '0;
      ovf_q        <= 1'b0;
      x_msb_q      <= 1'b0;
      sh_q         <= '0;
      quo_q        <= '0;
      rem_q        <= '0;
      bit_q        <= '0;
      err_ready_q  <= 1'b0;
      comp_valid_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      vec_len_q    <= vec_len_d;
      count_q      <= count_d;
      acc_q        <= acc_d;
      ovf_q        <= ovf_d;
      x_msb_q      <= x_msb_d;
      sh_q         <= sh_d;
      quo_q        <= quo_d;
      rem_q        <= rem_d;
      bit_q        <= bit_d;
      err_ready_q  <= err_ready_d;
      comp_valid_q <= comp_valid_d;
      busy_q       <= busy_d;
    end
  end

  assign err_ready  = err_ready_q;
  assign comp_valid = comp_valid_q;
  assign comp_value = acc_q;
  assign comp_ovf   = ovf_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_err_round_seq.sv
// Bench for err_round_seq: a default instance (ACC_W=24) and a narrow one (ACC_W=16)
// share all inputs; results are compared against an arithmetic model of the rounding.
module tb_err_round_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  vec_len = '0;
  logic        err_valid = 1'b0;
  logic [15:0] error_product = '0;
  logic        comp_ready = 1'b0;

  logic        err_ready, comp_valid, comp_ovf, busy;
  logic [23:0] comp_value;
  logic        err_ready_b, comp_valid_b, comp_ovf_b, busy_b;
  logic [15:0] comp_value_b;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [23:0] r_val;
  logic        r_ovf;
  logic [15:0] r_val16;
  logic        r_ovf16;
  int          acc_cyc[$];
  int          start_cyc;
  int          valid_cyc;
  bit          timed_out;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  err_round_seq #(.DATA_W(16), .M_BITS(14), .ACC_W(24), .LEN_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .vec_len(vec_len),
    .err_valid(err_valid), .err_ready(err_ready), .error_product(error_product),
    .comp_valid(comp_valid), .comp_ready(comp_ready), .comp_value(comp_value),
    .comp_ovf(comp_ovf), .busy(busy)
  );

  err_round_seq #(.DATA_W(16), .M_BITS(14), .ACC_W(16), .LEN_W(8)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start), .vec_len(vec_len),
    .err_valid(err_valid), .err_ready(err_ready_b), .error_product(error_product),
    .comp_valid(comp_valid_b), .comp_ready(comp_ready), .comp_value(comp_value_b),
    .comp_ovf(comp_ovf_b), .busy(busy_b)
  );

  // Round to a multiple of 4 (step S=2), bumping up when the product's MSB is set
  function automatic longint ref_round(input logic [15:0] x);
    longint q;
    q = longint'(x) / 4 + longint'(x[15]);
    return (q * 4) % 65536;
  endfunction

  function automatic longint ref_sum(input int len, input logic [15:0] xs [8],
                                     input int accw, output bit ovf);
    longint s, mx;
    mx = (longint'(1) << accw) - 1;
    s = 0;
    ovf = 1'b0;
    for (int i = 0; i < len; i++) begin
      s += ref_round(xs[i]);
      if (s > mx) begin
        s = mx;
        ovf = 1'b1;
      end
    end
    return s;
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  // Drives one vector up to the point where the result is presented; no handshake
  task automatic run_vec(input int len, input logic [15:0] xs [8], input int max_gap);
    int n;
    int gap;
    timed_out = 1'b0;
    acc_cyc.delete();
    start = 1'b1;
    vec_len = 8'(len);
    start_cyc = cyc;
    tick();
    start = 1'b0;
    for (int i = 0; i < len; i++) begin
      gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
      if (gap > 0) begin
        err_valid = 1'b0;
        repeat (gap) tick();
      end
      err_valid = 1'b1;
      error_product = xs[i];
      n = 0;
      while (!err_ready && n < 100) begin
        tick();
        n++;
      end
      if (!err_ready) begin
        timed_out = 1'b1;
        break;
      end
      acc_cyc.push_back(cyc);
      tick();
    end
    err_valid = 1'b0;
    error_product = 16'($urandom);
    n = 0;
    while (!comp_valid && n < 100) begin
      tick();
      n++;
    end
    if (!comp_valid) timed_out = 1'b1;
    valid_cyc = cyc;
    r_val = comp_value;
    r_ovf = comp_ovf;
    r_val16 = comp_value_b;
    r_ovf16 = comp_ovf_b;
  endtask

  task automatic finish_vec();
    comp_ready = 1'b1;
    tick();
    comp_ready = 1'b0;
  endtask

  task automatic test_reset();
    checks += 5;
    if (err_ready !== 1'b0) begin failures++; $display("FAIL reset_err_ready got=%b exp=0", err_ready); end
    if (comp_valid !== 1'b0) begin failures++; $display("FAIL reset_comp_valid got=%b exp=0", comp_valid); end
    if (comp_value !== 24'h0) begin failures++; $display("FAIL reset_comp_value got=%h exp=0", comp_value); end
    if (comp_ovf !== 1'b0) begin failures++; $display("FAIL reset_comp_ovf got=%b exp=0", comp_ovf); end
    if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
  endtask

  task automatic test_rounding();
    logic [15:0] xs [8];
    logic [15:0] vals [3];
    bit ovf;
    longint expv;
    vals = '{16'h0007, 16'h8003, 16'hFFFF};
    for (int k = 0; k < 3; k++) begin
      xs = '{default: 16'h0};
      xs[0] = vals[k];
      run_vec(1, xs, 0);
      expv = ref_sum(1, xs, 24, ovf);
      checks += 4;
      if (timed_out) begin failures++; $display("FAIL round_timeout x=%h", vals[k]); end
      if (r_val !== 24'(expv)) begin failures++; $display("FAIL round_value x=%h got=%h exp=%h", vals[k], r_val, 24'(expv)); end
      if (r_ovf !== ovf) begin failures++; $display("FAIL round_ovf got=%b exp=%b", r_ovf, ovf); end
      // Counting the accept cycle as cycle 1
      if (acc_cyc.size() != 1 || valid_cyc - acc_cyc[0] + 1 != 19) begin
        failures++; $display("FAIL round_latency got=%0d exp=19", valid_cyc - (acc_cyc.size() > 0 ? acc_cyc[0] : 0) + 1);
      end
      finish_vec();
    end
  endtask

  task automatic test_vector();
    logic [15:0] xs [8];
    bit ovf;
    longint expv;
    xs = '{default: 16'h0};
    xs[0] = 16'h0007; xs[1] = 16'h8003; xs[2] = 16'h0010;
    run_vec(3, xs, 0);
    expv = ref_sum(3, xs, 24, ovf);
    checks += 4;
    if (timed_out) begin failures++; $display("FAIL vector_timeout"); end
    if (r_val !== 24'(expv)) begin failures++; $display("FAIL vector_value got=%h exp=%h", r_val, 24'(expv)); end
    if (r_ovf !== 1'b0) begin failures++; $display("FAIL vector_ovf got=%b exp=0", r_ovf); end
    if (acc_cyc.size() != 3 || acc_cyc[1] - acc_cyc[0] != 18 || acc_cyc[2] - acc_cyc[1] != 18) begin
      failures++; $display("FAIL vector_spacing accepts=%0d exp 3 spaced by 18", acc_cyc.size());
    end
    finish_vec();
  endtask

  task automatic test_empty_stray_start();
    logic [15:0] xs [8];
    xs = '{default: 16'h0};
    run_vec(0, xs, 0);
    checks += 3;
    if (timed_out) begin failures++; $display("FAIL empty_timeout"); end
    if (valid_cyc - start_cyc != 1) begin failures++; $display("FAIL empty_latency got=%0d exp=1", valid_cyc - start_cyc); end
    if (r_val !== 24'h0) begin failures++; $display("FAIL empty_value got=%h exp=0", r_val); end
    vec_len = 8'd5;
    for (int i = 0; i < 5; i++) begin
      start = i[0];
      tick();
      checks += 3;
      if (comp_valid !== 1'b1) begin failures++; $display("FAIL stray_valid cyc=%0d got=%b exp=1", i, comp_valid); end
      if (comp_value !== 24'h0) begin failures++; $display("FAIL stray_value cyc=%0d got=%h exp=0", i, comp_value); end
      if (busy !== 1'b1) begin failures++; $display("FAIL stray_busy cyc=%0d got=%b exp=1", i, busy); end
    end
    start = 1'b1;
    comp_ready = 1'b1;
    tick();
    start = 1'b0;
    comp_ready = 1'b0;
    checks += 2;
    if (comp_valid !== 1'b0) begin failures++; $display("FAIL handshake_valid got=%b exp=0", comp_valid); end
    if (busy !== 1'b0) begin failures++; $display("FAIL handshake_start_ignored busy=%b exp=0", busy); end
    tick();
    checks += 1;
    if (busy !== 1'b0 || err_ready !== 1'b0) begin failures++; $display("FAIL idle_after_handshake busy=%b err_ready=%b exp=0", busy, err_ready); end
  endtask

  task automatic test_saturation();
    logic [15:0] xs [8];
    bit ovf16, ovf24;
    longint e16, e24;
    xs = '{default: 16'h0};
    xs[0] = 16'hFFF0; xs[1] = 16'h0010;
    run_vec(2, xs, 0);
    e16 = ref_sum(2, xs, 16, ovf16);
    e24 = ref_sum(2, xs, 24, ovf24);
    checks += 5;
    if (timed_out) begin failures++; $display("FAIL sat_timeout"); end
    if (r_val16 !== 16'(e16)) begin failures++; $display("FAIL sat_value got=%h exp=%h", r_val16, 16'(e16)); end
    if (r_ovf16 !== ovf16) begin failures++; $display("FAIL sat_ovf got=%b exp=%b", r_ovf16, ovf16); end
    if (r_val !== 24'(e24)) begin failures++; $display("FAIL wide_value got=%h exp=%h", r_val, 24'(e24)); end
    if (r_ovf !== ovf24) begin failures++; $display("FAIL wide_ovf got=%b exp=%b", r_ovf, ovf24); end
    finish_vec();
    tick();
    checks += 1;
    if (comp_ovf_b !== 1'b1) begin failures++; $display("FAIL sat_ovf_hold got=%b exp=1", comp_ovf_b); end
    start = 1'b1;
    vec_len = 8'd1;
    tick();
    start = 1'b0;
    checks += 1;
    if (comp_ovf_b !== 1'b0) begin failures++; $display("FAIL sat_ovf_clear got=%b exp=0", comp_ovf_b); end
    err_valid = 1'b1;
    error_product = 16'h0004;
    tick();
    err_valid = 1'b0;
    for (int n = 0; n < 100 && !comp_valid; n++) tick();
    finish_vec();
  endtask

  task automatic test_backpressure();
    logic [15:0] x;
    x = 16'($urandom);
    start = 1'b1;
    vec_len = 8'd1;
    err_valid = 1'b0;
    tick();
    start = 1'b0;
    for (int i = 0; i < 7; i++) begin
      error_product = 16'($urandom);
      tick();
      checks += 2;
      if (err_ready !== 1'b1) begin failures++; $display("FAIL bp_err_ready cyc=%0d got=%b exp=1", i, err_ready); end
      if (comp_valid !== 1'b0) begin failures++; $display("FAIL bp_early_valid cyc=%0d got=%b exp=0", i, comp_valid); end
    end
    err_valid = 1'b1;
    error_product = x;
    tick();
    err_valid = 1'b0;
    for (int n = 0; n < 100 && !comp_valid; n++) tick();
    checks += 1;
    if (comp_valid !== 1'b1 || comp_value !== 24'(ref_round(x))) begin
      failures++; $display("FAIL bp_value valid=%b got=%h exp=%h", comp_valid, comp_value, 24'(ref_round(x)));
    end
    finish_vec();
  endtask

  task automatic test_reset_mid_div();
    logic [15:0] xs [8];
    start = 1'b1;
    vec_len = 8'd1;
    tick();
    start = 1'b0;
    err_valid = 1'b1;
    error_product = 16'hFFFF;
    tick();
    err_valid = 1'b0;
    repeat (4) tick();
    checks += 1;
    if (busy !== 1'b1) begin failures++; $display("FAIL div_busy got=%b exp=1", busy); end
    rst_n = 1'b0;
    #1;
    checks += 5;
    if (err_ready !== 1'b0) begin failures++; $display("FAIL rst_err_ready got=%b exp=0", err_ready); end
    if (comp_valid !== 1'b0) begin failures++; $display("FAIL rst_comp_valid got=%b exp=0", comp_valid); end
    if (comp_value !== 24'h0) begin failures++; $display("FAIL rst_comp_value got=%h exp=0", comp_value); end
    if (comp_ovf !== 1'b0) begin failures++; $display("FAIL rst_comp_ovf got=%b exp=0", comp_ovf); end
    if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", busy); end
    tick();
    tick();
    rst_n = 1'b1;
    repeat (20) tick();
    checks += 1;
    if (comp_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL rst_no_partial valid=%b busy=%b exp=0", comp_valid, busy); end
    xs = '{default: 16'h0};
    xs[0] = 16'h0004;
    run_vec(1, xs, 0);
    checks += 1;
    if (timed_out || r_val !== 24'(ref_round(16'h0004))) begin
      failures++; $display("FAIL rst_recover got=%h exp=%h", r_val, 24'(ref_round(16'h0004)));
    end
    finish_vec();
  endtask

  task automatic test_random();
    logic [15:0] xs [8];
    bit ovf16, ovf24;
    longint e16, e24;
    int len;
    int hold;
    logic [23:0] held;
    for (int t = 0; t < 20; t++) begin
      len = int'($urandom_range(5, 1));
      for (int i = 0; i < 8; i++) xs[i] = 16'($urandom);
      run_vec(len, xs, 3);
      e16 = ref_sum(len, xs, 16, ovf16);
      e24 = ref_sum(len, xs, 24, ovf24);
      checks += 5;
      if (timed_out) begin failures++; $display("FAIL rand_timeout vec=%0d", t); end
      if (r_val !== 24'(e24)) begin failures++; $display("FAIL rand_value24 vec=%0d got=%h exp=%h", t, r_val, 24'(e24)); end
      if (r_ovf !== ovf24) begin failures++; $display("FAIL rand_ovf24 vec=%0d got=%b exp=%b", t, r_ovf, ovf24); end
      if (r_val16 !== 16'(e16)) begin failures++; $display("FAIL rand_value16 vec=%0d got=%h exp=%h", t, r_val16, 16'(e16)); end
      if (r_ovf16 !== ovf16) begin failures++; $display("FAIL rand_ovf16 vec=%0d got=%b exp=%b", t, r_ovf16, ovf16); end
      hold = int'($urandom_range(3, 0));
      held = 24'(e24);
      repeat (hold) tick();
      checks += 1;
      if (comp_valid !== 1'b1 || comp_value !== held) begin
        failures++; $display("FAIL rand_hold vec=%0d valid=%b got=%h exp=%h", t, comp_valid, comp_value, held);
      end
      finish_vec();
    end
  endtask

  initial begin
    #1;
    test_reset();
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    test_rounding();
    test_vector();
    test_empty_stray_start();
    test_saturation();
    test_backpressure();
    test_reset_mid_div();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/err_round_seq.md
Name: err_round_seq

Overview:
- Sequencer for the round-toward-step error-compensation path of the low-voltage MAC unit.
- Accepts one error product per handshake and rounds it with a bit-serial restoring shift-subtract divider, one quotient bit per cycle.
- Accumulates the rounded values over a dot-product of programmable length, then presents the compensation sum to the MAC output stage with valid/ready.

Parameters:
- DATA_W, 16, error-product width.
- M_BITS, 14, MSBs kept after rounding; step S = DATA_W-M_BITS, divisor D = 2^S. Legal range 1..DATA_W.
- ACC_W, 24, compensation accumulator width. Must be at least DATA_W.
- LEN_W, 8, width of the vector-length field.

Ports:
- clk, input, 1, rising-edge clock.
- rst_n, input, 1, asynchronous active-low reset.
- start, input, 1, begin a new dot-product; sampled only in IDLE.
- vec_len, input, LEN_W, number of error products; latched on start.
- err_valid, input, 1, error_product is valid.
- err_ready, output, 1, block accepts error_product.
- error_product, input, DATA_W, unsigned error product from the MAC.
- comp_valid, output, 1, comp_value is valid.
- comp_ready, input, 1, downstream accepts comp_value.
- comp_value, output, ACC_W, accumulated rounded error.
- comp_ovf, output, 1, sticky: accumulator saturated during this vector.
- busy, output, 1, high in every state except IDLE.

Behaviour:
- Reset values: err_ready=0, comp_valid=0, comp_value=0, comp_ovf=0, busy=0. Internal accumulator, element count, quotient, remainder and bit counter are all cleared. Reset during any state aborts the operation; after release the FSM is in IDLE and no partial result is ever emitted.
- FSM states: IDLE, LOAD, DIV, ACC, OUT.
- IDLE:
  - On start=1, latch vec_len and clear accumulator, count and comp_ovf.
  - If vec_len==0, go to OUT. Otherwise go to LOAD.
- LOAD:
  - err_ready=1 only in this state.
  - On err_valid && err_ready, capture error_product and clear quotient, remainder and bit counter, then go to DIV.
- DIV: exactly DATA_W cycles, processing MSB first. Each cycle:
  - Shift the remainder left and append the next operand bit.
  - If remainder >= D, subtract D and set the quotient LSB to 1; otherwise the quotient bit is 0.
  - After DATA_W cycles, quotient = floor(x / 2^S). Then go to ACC.
- ACC (1 cycle):
  - r = ((quotient + x[DATA_W-1]) << S) mod 2^DATA_W, i.e. truncated to DATA_W bits. Example with defaults: x=0xFFFF gives r=0x0000.
  - acc = acc + zero-extend(r). The sum saturates at 2^ACC_W-1 and sets comp_ovf.
  - count increments. If count == vec_len, go to OUT; else go to LOAD.
- Throughput: one element per DATA_W+2 cycles when err_valid is held high (accept cycle + DATA_W divide cycles + 1 accumulate cycle).
- OUT:
  - comp_valid=1 and comp_value=acc, both held stable until comp_ready=1.
  - On the handshake cycle go to IDLE. comp_valid drops the next cycle. comp_value and comp_ovf hold until the next start.
- start is ignored outside IDLE, including a start in the same cycle as the OUT handshake.
- err_valid is ignored outside LOAD, and error_product is not sampled while in DIV.
- comp_ready outside OUT has no effect.
- All arithmetic is unsigned.

Test Plan (defaults unless noted, S=2, D=4):
- Rounding: vec_len=1 with x=0x0007 → comp_value=0x000004. x=0x8003 → 0x008004. x=0xFFFF → 0x000000. Each comp_valid rises 19 cycles after the accept cycle.
- Vector: vec_len=3 with 0x0007, 0x8003, 0x0010 and err_valid held high → accepts spaced 18 cycles apart; comp_value=0x008018, comp_ovf=0.
- Empty vector and stray start: vec_len=0 start → comp_valid=1 one cycle later with comp_value=0. Hold comp_ready=0 for 5 cycles while pulsing start → value stable, start ignored, return to IDLE after comp_ready.
- Saturation: ACC_W=16, vec_len=2, inputs 0xFFF0 then 0x0010 → 0xFFF4 + 0x0010 saturates; comp_value=0xFFFF, comp_ovf=1. A following start clears comp_ovf.
- Backpressure in: err_valid low for 7 cycles in LOAD → err_ready stays 1, FSM stays in LOAD, no count increment.
- Reset mid-DIV: assert rst_n=0 at cycle 5 of DIV → all outputs reach reset values immediately. After release a new vec_len=1 with x=0x0004 yields 0x000004.
